// File: rtl/multi_ball_mapper.sv
// multi_ball_mapper: pipelined per-pixel colour generator for up to N_BALLS
// circular balls. It sits between the VGA DrawX/DrawY counters and the RGB
// output registers.
//
// Game logic may write the shadow register file at any time. On frame_start
// the shadow file is copied to the active file, so a frame never shows a
// half-applied update. Each pixel is tested against every active ball.
// The lowest-index hit wins. The pixel then gets fill, edge ring or
// background colour, always 3 cycles after DrawX/DrawY are sampled.
//
// Build option: define BALL_EDGE_EN to build a white ring EDGE_W pixels wide
// just outside every ball's radius. Without it, the ring logic is absent.
// Pixels that would have landed on a ring then fall through to the next ball
// or to the background.

module multi_ball_mapper #(
  parameter int N_BALLS = 4,
  parameter int COORD_W = 10,
  parameter int EDGE_W  = 2,
  parameter int COLOR_W = 8,
  localparam int IDX_W  = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [COORD_W-1:0]   wr_x,
  input  logic [COORD_W-1:0]   wr_y,
  input  logic [COORD_W-1:0]   wr_size,
  input  logic                 wr_active,
  input  logic [3*COLOR_W-1:0] wr_color,
  input  logic                 pix_valid_in,
  input  logic [COORD_W-1:0]   DrawX,
  input  logic [COORD_W-1:0]   DrawY,
  output logic [COLOR_W-1:0]   Red,
  output logic [COLOR_W-1:0]   Green,
  output logic [COLOR_W-1:0]   Blue,
  output logic                 ball_on,
  output logic [IDX_W-1:0]     ball_id,
  output logic                 pix_valid_out
);

  // Signed coordinate difference, squared-distance width, gradient widths.
  localparam int D_W  = COORD_W + 1;
  localparam int D2_W = 2 * COORD_W + 3;
  localparam int XS_W = COORD_W - 3;
  localparam int BG_W = (XS_W > 7) ? XS_W : 7;

  // Reject parameter sets the datapath is not sized for.
  if (N_BALLS < 1 || N_BALLS > 16 || COORD_W < 4 || EDGE_W < 0) begin : g_bad_params
    $error("multi_ball_mapper: unsupported parameter set");
  end

  typedef struct packed {
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [COORD_W-1:0]   size;
    logic                 active;
    logic [3*COLOR_W-1:0] color;
  } ball_t;

  // ---------------------------------------------------------------------
  // Shadow / active register files
  // ---------------------------------------------------------------------
  ball_t shadow_q [N_BALLS];
  ball_t shadow_d [N_BALLS];
  ball_t active_q [N_BALLS];
  ball_t active_d [N_BALLS];

  // Apply the shadow write, then commit shadow (including that write) on frame_start.
  always_comb begin
    for (int i = 0; i < N_BALLS; i++) begin
      // NOTE: every output gets its hold value first, so no path leaves it unassigned and no latch is inferred.
      shadow_d[i] = shadow_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        shadow_d[i].x      = wr_x;
        shadow_d[i].y      = wr_y;
        shadow_d[i].size   = wr_size;
        shadow_d[i].active = wr_active;
        shadow_d[i].color  = wr_color;
      end
      active_d[i] = frame_start ? shadow_d[i] : active_q[i];
    end
  end

  // File storage; Reset overrides any write or commit in the same cycle.
  always_ff @(posedge Clk) begin
    // NOTE: the ball files are reset because reset must leave every slot inactive; pipeline datapath registers are left unreset since their valid bit masks them.
    if (Reset) begin
      for (int i = 0; i < N_BALLS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: per-ball signed offsets and parameter snapshot
  // ---------------------------------------------------------------------
  logic signed [D_W-1:0]  s1_dx_q    [N_BALLS];
  logic signed [D_W-1:0]  s1_dx_d    [N_BALLS];
  logic signed [D_W-1:0]  s1_dy_q    [N_BALLS];
  logic signed [D_W-1:0]  s1_dy_d    [N_BALLS];
  logic [COORD_W-1:0]     s1_size_q  [N_BALLS];
  logic [COORD_W-1:0]     s1_size_d  [N_BALLS];
  logic [3*COLOR_W-1:0]   s1_color_q [N_BALLS];
  logic [3*COLOR_W-1:0]   s1_color_d [N_BALLS];
  logic [N_BALLS-1:0]     s1_act_q;
  logic [N_BALLS-1:0]     s1_act_d;
  logic [XS_W-1:0]        s1_xs_q;
  logic [XS_W-1:0]        s1_xs_d;
  logic                   s1_valid_q;
  logic                   s1_valid_d;

  // The gradient needs only DrawX[COORD_W-1:3]; the low bits are dropped here.
  logic unused_draw_lsb;
  assign unused_draw_lsb = ^DrawX[2:0];

  // Offsets use the active file as it stood before this edge, so a commit on the same edge is not yet visible.
  always_comb begin
    s1_valid_d = pix_valid_in;
    s1_xs_d    = DrawX[COORD_W-1:3];
    for (int i = 0; i < N_BALLS; i++) begin
      s1_dx_d[i]    = $signed({1'b0, DrawX}) - $signed({1'b0, active_q[i].x});
      s1_dy_d[i]    = $signed({1'b0, DrawY}) - $signed({1'b0, active_q[i].y});
      s1_size_d[i]  = active_q[i].size;
      s1_act_d[i]   = active_q[i].active;
      s1_color_d[i] = active_q[i].color;
    end
  end

  // Stage 1 register; only the valid bit is cleared by reset.
  always_ff @(posedge Clk) begin
    if (Reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= s1_valid_d;
    s1_xs_q    <= s1_xs_d;
    s1_dx_q    <= s1_dx_d;
    s1_dy_q    <= s1_dy_d;
    s1_size_q  <= s1_size_d;
    s1_act_q   <= s1_act_d;
    s1_color_q <= s1_color_d;
  end

  // ---------------------------------------------------------------------
  // Stage 2: squared distance and squared radii (full width, no truncation)
  // ---------------------------------------------------------------------
  logic [D2_W-1:0]        s2_d2_q    [N_BALLS];
  logic [D2_W-1:0]        s2_d2_d    [N_BALLS];
  logic [D2_W-1:0]        s2_rin_q   [N_BALLS];
  logic [D2_W-1:0]        s2_rin_d   [N_BALLS];
`ifdef BALL_EDGE_EN
  logic [D2_W-1:0]        s2_rout_q  [N_BALLS];
  logic [D2_W-1:0]        s2_rout_d  [N_BALLS];
  logic [D2_W-1:0]        s2_rsum    [N_BALLS];
`endif
  logic [3*COLOR_W-1:0]   s2_color_q [N_BALLS];
  logic [N_BALLS-1:0]     s2_act_q;
  logic [XS_W-1:0]        s2_xs_q;
  logic                   s2_valid_q;

  // Offsets are sign-extended to the product width before squaring.
  always_comb begin
    for (int i = 0; i < N_BALLS; i++) begin
      s2_d2_d[i]  = $unsigned(D2_W'(s1_dx_q[i]) * D2_W'(s1_dx_q[i])
                            + D2_W'(s1_dy_q[i]) * D2_W'(s1_dy_q[i]));
      s2_rin_d[i] = D2_W'(s1_size_q[i]) * D2_W'(s1_size_q[i]);
`ifdef BALL_EDGE_EN
      s2_rsum[i]   = D2_W'(s1_size_q[i]) + D2_W'(EDGE_W);
      s2_rout_d[i] = s2_rsum[i] * s2_rsum[i];
`endif
    end
  end

  // Stage 2 register.
  always_ff @(posedge Clk) begin
    if (Reset) s2_valid_q <= 1'b0;
    else       s2_valid_q <= s1_valid_q;
    s2_xs_q    <= s1_xs_q;
    s2_d2_q    <= s2_d2_d;
    s2_rin_q   <= s2_rin_d;
`ifdef BALL_EDGE_EN
    s2_rout_q  <= s2_rout_d;
`endif
    s2_act_q   <= s1_act_q;
    s2_color_q <= s1_color_q;
  end

  // ---------------------------------------------------------------------
  // Stage 3: per-ball fill / ring classification
  // ---------------------------------------------------------------------
  logic [N_BALLS-1:0]     s3_fill_q;
  logic [N_BALLS-1:0]     s3_fill_d;
  logic [N_BALLS-1:0]     s3_hit_q;
  logic [N_BALLS-1:0]     s3_hit_d;
  logic [3*COLOR_W-1:0]   s3_color_q [N_BALLS];
  logic [XS_W-1:0]        s3_xs_q;
  logic                   s3_valid_q;

  // Fill is strictly inside the radius; the ring covers the EDGE_W band beyond it.
  always_comb begin
    for (int i = 0; i < N_BALLS; i++) begin
      s3_fill_d[i] = s2_act_q[i] && (s2_d2_q[i] < s2_rin_q[i]);
`ifdef BALL_EDGE_EN
      s3_hit_d[i]  = s3_fill_d[i] || (s2_act_q[i] && (s2_d2_q[i] < s2_rout_q[i]));
`else
      s3_hit_d[i]  = s3_fill_d[i];
`endif
    end
  end

  // Stage 3 register.
  always_ff @(posedge Clk) begin
    if (Reset) s3_valid_q <= 1'b0;
    else       s3_valid_q <= s2_valid_q;
    s3_xs_q    <= s2_xs_q;
    s3_fill_q  <= s3_fill_d;
    s3_hit_q   <= s3_hit_d;
    s3_color_q <= s2_color_q;
  end

  // ---------------------------------------------------------------------
  // Output stage: priority select, colour mux, registered outputs
  // ---------------------------------------------------------------------
  logic                 win_any;
  logic                 win_fill;
  logic [IDX_W-1:0]     win_id;
  logic [3*COLOR_W-1:0] win_color;
  logic [BG_W-1:0]      bg_blue;

  logic [COLOR_W-1:0]   red_q;
  logic [COLOR_W-1:0]   red_d;
  logic [COLOR_W-1:0]   green_q;
  logic [COLOR_W-1:0]   green_d;
  logic [COLOR_W-1:0]   blue_q;
  logic [COLOR_W-1:0]   blue_d;
  logic                 on_q;
  logic                 on_d;
  logic [IDX_W-1:0]     id_q;
  logic [IDX_W-1:0]     id_d;
  logic                 valid_q;
  logic                 valid_d;

  // Scan from the highest index down so the lowest-index hit is the last (winning) assignment.
  always_comb begin
    win_any   = 1'b0;
    win_fill  = 1'b0;
    win_id    = '0;
    win_color = '0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (s3_hit_q[i]) begin
        win_any   = 1'b1;
        win_fill  = s3_fill_q[i];
        win_id    = IDX_W'(i);
        win_color = s3_color_q[i];
      end
    end

    bg_blue = BG_W'(7'h7F) - BG_W'(s3_xs_q);

    valid_d = s3_valid_q;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    on_d    = 1'b0;
    id_d    = '0;
    if (s3_valid_q) begin
      if (win_any) begin
        on_d = 1'b1;
        id_d = win_id;
        if (win_fill) begin
          red_d   = win_color[3*COLOR_W-1:2*COLOR_W];
          green_d = win_color[2*COLOR_W-1:COLOR_W];
          blue_d  = win_color[COLOR_W-1:0];
        end else begin
          red_d   = '1;
          green_d = '1;
          blue_d  = '1;
        end
      end else begin
        blue_d = COLOR_W'(bg_blue);
      end
    end
  end

  // Output register; reset blanks the outputs on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      on_q    <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      on_q    <= on_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  assign Red           = red_q;
  assign Green         = green_q;
  assign Blue          = blue_q;
  assign ball_on       = on_q;
  assign ball_id       = id_q;
  assign pix_valid_out = valid_q;

endmodule

// File: tb/tb_multi_ball_mapper.sv
// Self-checking bench for multi_ball_mapper. A behavioural model derives each
// pixel's colour from plain integer geometry. It keeps the expected outputs
// in a 3-deep delay line. Directed steps follow the test plan; a randomized
// phase then places pixels near the live balls.

module tb_multi_ball_mapper;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int EW = 2;
  localparam int KW = 8;
  localparam int IW = 2;
`ifdef BALL_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef logic [27:0] out_t;  // {valid, R, G, B, ball_on, ball_id}

  logic           Clk = 1'b0;
  logic           Reset;
  logic           frame_start;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [CW-1:0]  wr_x;
  logic [CW-1:0]  wr_y;
  logic [CW-1:0]  wr_size;
  logic           wr_active;
  logic [3*KW-1:0] wr_color;
  logic           pix_valid_in;
  logic [CW-1:0]  DrawX;
  logic [CW-1:0]  DrawY;
  logic [KW-1:0]  Red;
  logic [KW-1:0]  Green;
  logic [KW-1:0]  Blue;
  logic           ball_on;
  logic [IW-1:0]  ball_id;
  logic           pix_valid_out;

  out_t dut_out;
  assign dut_out = {pix_valid_out, Red, Green, Blue, ball_on, ball_id};

  multi_ball_mapper #(
    .N_BALLS(N), .COORD_W(CW), .EDGE_W(EW), .COLOR_W(KW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_size(wr_size), .wr_active(wr_active), .wr_color(wr_color),
    .pix_valid_in(pix_valid_in), .DrawX(DrawX), .DrawY(DrawY),
    .Red(Red), .Green(Green), .Blue(Blue), .ball_on(ball_on),
    .ball_id(ball_id), .pix_valid_out(pix_valid_out)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  int          sh_x [N];
  int          sh_y [N];
  int          sh_s [N];
  bit          sh_a [N];
  logic [23:0] sh_c [N];
  int          ac_x [N];
  int          ac_y [N];
  int          ac_s [N];
  bit          ac_a [N];
  logic [23:0] ac_c [N];
  out_t        pipe [3];
  out_t        exp_out = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input out_t got, input out_t want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Colour of one pixel from the active balls, using plain circle geometry.
  function automatic out_t eval_pixel(input bit v, input int x, input int y);
    int dx;
    int dy;
    int d2;
    int s;
    if (!v) return '0;
    for (int i = 0; i < N; i++) begin
      if (ac_a[i]) begin
        dx = x - ac_x[i];
        dy = y - ac_y[i];
        d2 = dx * dx + dy * dy;
        s  = ac_s[i];
        if (d2 < s * s)
          return {1'b1, ac_c[i], 1'b1, IW'(i)};
        if (EDGE_EN && d2 < (s + EW) * (s + EW))
          return {1'b1, 24'hFFFFFF, 1'b1, IW'(i)};
      end
    end
    return {1'b1, 8'h00, 8'h00, 8'(127 - (x >> 3)), 1'b0, 2'd0};
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        sh_x[i] = 0; sh_y[i] = 0; sh_s[i] = 0; sh_a[i] = 0; sh_c[i] = '0;
        ac_x[i] = 0; ac_y[i] = 0; ac_s[i] = 0; ac_a[i] = 0; ac_c[i] = '0;
      end
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      exp_out = '0;
    end else begin
      exp_out = pipe[0];
      pipe[0] = pipe[1];
      pipe[1] = pipe[2];
      pipe[2] = eval_pixel(pix_valid_in, int'(DrawX), int'(DrawY));
      if (wr_en && int'(wr_idx) < N) begin
        sh_x[wr_idx] = int'(wr_x);
        sh_y[wr_idx] = int'(wr_y);
        sh_s[wr_idx] = int'(wr_size);
        sh_a[wr_idx] = wr_active;
        sh_c[wr_idx] = wr_color;
      end
      if (frame_start) begin
        for (int i = 0; i < N; i++) begin
          ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_s[i] = sh_s[i];
          ac_a[i] = sh_a[i]; ac_c[i] = sh_c[i];
        end
      end
    end
  endtask

  // One clock: update the model at the edge, compare outputs 1 ns later.
  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check("pipe_out", dut_out, exp_out);
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0;
    wr_x = '0; wr_y = '0; wr_size = '0; wr_active = 1'b0; wr_color = '0;
    pix_valid_in = 1'b0; DrawX = '0; DrawY = '0;
  endtask

  task automatic set_write(input int idx, input int x, input int y, input int s,
                           input bit a, input logic [23:0] c);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_x = CW'(x); wr_y = CW'(y);
    wr_size = CW'(s); wr_active = a; wr_color = c;
  endtask

  // Present one pixel, flush with invalid cycles, check its output 3 edges later.
  task automatic run_pixel(input bit v, input int x, input int y,
                           input out_t want, input string tag);
    pix_valid_in = v; DrawX = CW'(x); DrawY = CW'(y);
    tick();
    pix_valid_in = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
    repeat (3) tick();
    check(tag, dut_out, want);
  endtask

  initial begin
    int b;
    int off;

    // Reset
    idle_inputs();
    Reset = 1'b1;
    tick();
    tick();
    check("reset_out", dut_out, 28'h0);
    Reset = 1'b0;

    // Ball 0 written together with frame_start (write-through commit)
    set_write(0, 320, 240, 4, 1'b1, 24'h005500);
    frame_start = 1'b1;
    tick();
    wr_en = 1'b0; frame_start = 1'b0;
    run_pixel(1'b1, 320, 240, {1'b1, 8'h00, 8'h55, 8'h00, 1'b1, 2'd0}, "ball0_fill");
    run_pixel(1'b1, 325, 240, EDGE_EN ? {1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 2'd0}
                                      : {1'b1, 8'h00, 8'h00, 8'h57, 1'b0, 2'd0}, "ring_325");
    run_pixel(1'b1, 330, 240, {1'b1, 8'h00, 8'h00, 8'h56, 1'b0, 2'd0}, "bg_330");

    // Ball 1 overlapping ball 0: lower index wins where both hit
    set_write(1, 320, 240, 8, 1'b1, 24'hAA0000);
    frame_start = 1'b1;
    tick();
    wr_en = 1'b0; frame_start = 1'b0;
    run_pixel(1'b1, 320, 240, {1'b1, 8'h00, 8'h55, 8'h00, 1'b1, 2'd0}, "prio_ball0");
    run_pixel(1'b1, 326, 240, {1'b1, 8'hAA, 8'h00, 8'h00, 1'b1, 2'd1}, "ball1_fill");

    // Shadow-only write is invisible until the commit
    set_write(0, 100, 240, 4, 1'b1, 24'h005500);
    tick();
    wr_en = 1'b0;
    run_pixel(1'b1, 100, 240, {1'b1, 8'h00, 8'h00, 8'h73, 1'b0, 2'd0}, "shadow_only");

    // Pixel on the commit edge still sees the old file; ball 2 joins the same commit
    set_write(2, 500, 100, 5, 1'b1, 24'h0000CC);
    frame_start = 1'b1;
    run_pixel(1'b1, 100, 240, {1'b1, 8'h00, 8'h00, 8'h73, 1'b0, 2'd0}, "commit_edge_pix");
    run_pixel(1'b1, 100, 240, {1'b1, 8'h00, 8'h55, 8'h00, 1'b1, 2'd0}, "after_commit");
    run_pixel(1'b1, 500, 100, {1'b1, 8'h00, 8'h00, 8'hCC, 1'b1, 2'd2}, "ball2_same_frame");

    // Invalid pixel over a ball
    run_pixel(1'b0, 100, 240, 28'h0, "invalid_pix");

    // Mid-stream reset with continuous valid pixels
    pix_valid_in = 1'b1; DrawX = CW'(100); DrawY = CW'(240);
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    check("reset_mid", dut_out, 28'h0);
    Reset = 1'b0;
    repeat (3) tick();
    check("post_reset_3", dut_out, 28'h0);
    tick();
    check("post_reset_bg", dut_out, {1'b1, 8'h00, 8'h00, 8'h73, 1'b0, 2'd0});
    pix_valid_in = 1'b0;

    // Randomized phase: writes, commits, occasional reset, pixels near live balls
    for (int k = 0; k < 800; k++) begin
      Reset        = ($urandom_range(0, 299) == 0);
      wr_en        = ($urandom_range(0, 3) == 0);
      wr_idx       = IW'($urandom_range(0, N - 1));
      wr_x         = CW'($urandom_range(20, 620));
      wr_y         = CW'($urandom_range(20, 460));
      wr_size      = CW'($urandom_range(0, 12));
      wr_active    = ($urandom_range(0, 4) != 0);
      wr_color     = 24'($urandom);
      frame_start  = ($urandom_range(0, 11) == 0);
      pix_valid_in = ($urandom_range(0, 7) != 0);
      b            = int'($urandom_range(0, N - 1));
      off          = int'($urandom_range(0, 32)) - 16;
      DrawX        = CW'(ac_x[b] + off);
      off          = int'($urandom_range(0, 32)) - 16;
      DrawY        = CW'(ac_y[b] + off);
      tick();
    end

    idle_inputs();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
